// File: rtl/key_event_pkg.sv
// Shared types and widths for the key event classifier.
package key_event_pkg;

  localparam int unsigned MS_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } key_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: one-cycle tick every FREQ_MHZ*1000 cycles,
// restarted from zero whenever clr is high.
module ms_tick_gen #(
  parameter int unsigned FREQ_MHZ = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV   = FREQ_MHZ * 1000;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_fsm.sv
// Classifies a debounced key into short press, long press and double click.
// Define KEY_EVENT_REPEAT_EN to add auto-repeat pulses while a long hold lasts.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned FREQ_MHZ  = 50,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic busy
);

  if (LONG_MS == 0 || DCLICK_MS == 0 || REPEAT_MS == 0 ||
      LONG_MS >= 65536 || DCLICK_MS >= 65536) begin : g_cfg_check
    $error("key_event_fsm: timing parameters must be in 1..65535");
  end

  key_state_t          state, state_next;
  logic                key_d, armed;
  logic                press_evt, release_evt;
  logic                clr, tick;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                reach_long, reach_dclick;
  logic                short_nxt, long_nxt, dclick_nxt;

  // A key already held when reset releases must be seen released before it can start an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d <= 1'b1;
      armed <= 1'b0;
    end else begin
      key_d <= key_level;
      armed <= armed | key_level;
    end
  end

  assign press_evt   = key_d & ~key_level & armed;
  assign release_evt = ~key_d & key_level;
  assign clr         = (state_next != state);

  ms_tick_gen #(.FREQ_MHZ(FREQ_MHZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ms_cnt <= '0;
    else if (clr)                      ms_cnt <= '0;
    else if (tick && (ms_cnt != '1))   ms_cnt <= ms_cnt + MS_CNT_W'(1);
  end

  // True in the tick cycle that makes the count reach the threshold.
  assign reach_long   = tick && (ms_cnt == MS_CNT_W'(LONG_MS - 1));
  assign reach_dclick = tick && (ms_cnt == MS_CNT_W'(DCLICK_MS - 1));

`ifdef KEY_EVENT_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_hit;
  logic             repeat_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rep_cnt <= '0;
    else if (clr) rep_cnt <= '0;
    else if (tick) rep_cnt <= rep_hit ? '0 : rep_cnt + REP_W'(1);
  end

  assign rep_hit = tick && (rep_cnt == REP_W'(REPEAT_MS - 1));
`endif

  always_comb begin
    state_next = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    dclick_nxt = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    repeat_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (press_evt) state_next = PRESS1;
      end
      PRESS1: begin
        if (reach_long) begin
          long_nxt   = 1'b1;
          state_next = release_evt ? IDLE : LONG_HOLD;
        end else if (release_evt) begin
          state_next = WAIT2;
        end
      end
      WAIT2: begin
        if (reach_dclick) begin
          short_nxt  = 1'b1;
          state_next = press_evt ? PRESS1 : IDLE;
        end else if (press_evt) begin
          state_next = PRESS2;
        end
      end
      PRESS2: begin
        if (release_evt) begin
          dclick_nxt = 1'b1;
          state_next = IDLE;
        end
      end
      LONG_HOLD: begin
        if (release_evt) state_next = IDLE;
`ifdef KEY_EVENT_REPEAT_EN
        else repeat_nxt = rep_hit;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != IDLE);
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dclick_nxt;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= repeat_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/key_event_fsm.md
KEY_EVENT_FSM -- requirements
Module: key_event_fsm

Interface
REQ-001 SHALL have parameter FREQ_MHZ, default 50, clock frequency in MHz.
REQ-002 SHALL have parameter LONG_MS, default 1000, press duration in ms that qualifies as a long press.
REQ-003 SHALL have parameter DCLICK_MS, default 300, maximum release gap in ms for a double click.
REQ-004 SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have port key_level, input, 1, debounced synchronous key level: 0 = pressed, 1 = released.
REQ-008 SHALL have port short_press, output, 1, single-cycle pulse for a single short press.
REQ-009 SHALL have port long_press, output, 1, single-cycle pulse when a hold reaches LONG_MS.
REQ-010 SHALL have port double_click, output, 1, single-cycle pulse for a completed double click.
REQ-011 SHALL have port repeat_pulse, output, 1, single-cycle pulse during a long hold; constant 0 when the repeat feature is compiled out.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL register key_level once (key_d) and detect press_evt = key_d & ~key_level and release_evt = ~key_d & key_level.
REQ-014 SHALL derive a 1 ms tick from a prescaler of FREQ_MHZ*1000 cycles; the prescaler and ms counter clear on every state transition.
REQ-015 SHALL keep a saturating ms counter, 16 bits wide, incremented on each tick.
REQ-016 SHALL implement the states IDLE, PRESS1, WAIT2, PRESS2 and LONG_HOLD.
REQ-017 IDLE: on press_evt, SHALL go to PRESS1.
REQ-018 PRESS1: when the ms counter reaches LONG_MS, SHALL pulse long_press and go to LONG_HOLD; otherwise on release_evt SHALL go to WAIT2.
REQ-019 PRESS1: if release_evt coincides with reaching LONG_MS, SHALL pulse long_press and go to IDLE.
REQ-020 WAIT2: on press_evt before the count reaches DCLICK_MS, SHALL go to PRESS2.
REQ-021 WAIT2: when the count reaches DCLICK_MS, SHALL pulse short_press and go to IDLE; if press_evt occurs in that same cycle, SHALL pulse short_press and go to PRESS1.
REQ-022 PRESS2: on release_evt, SHALL pulse double_click and go to IDLE, regardless of hold duration.
REQ-023 LONG_HOLD: on release_evt, SHALL go to IDLE with no further pulse.
REQ-024 All outputs SHALL be registered; each pulse SHALL assert exactly one cycle, in the cycle after the qualifying edge or tick.
REQ-025 At most one of short_press, long_press and double_click SHALL be high in any cycle.

Reset
REQ-026 On rst_n low, SHALL force state IDLE, clear the prescaler and ms counter, set key_d = 1, and drive all outputs to 0.
REQ-027 Reset asserted mid-press SHALL discard the event; after release of reset with key_level = 0, no event SHALL occur until a fresh press_evt.

Configuration
REQ-028 With macro KEY_EVENT_REPEAT_EN defined, LONG_HOLD SHALL pulse repeat_pulse every REPEAT_MS ms (first pulse REPEAT_MS after long_press) until release.
REQ-029 With KEY_EVENT_REPEAT_EN undefined, the repeat logic SHALL be absent and repeat_pulse SHALL be tied to 0.

Structure
REQ-030 A shared package key_event_pkg SHALL hold the state enum typedef and MS_CNT_W = 16.
REQ-031 The prescaler SHALL be a sub-module ms_tick_gen (parameter FREQ_MHZ; ports clk, rst_n, clr, tick).

Verification
Scenarios use FREQ_MHZ=1, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3 (1 ms = 1000 cycles).
REQ-032 Press 3 ms, release, idle 6 ms -> one short_press pulse 5 ms after release; busy low afterwards.
REQ-033 Press 2 ms, release 2 ms, press 2 ms, release -> one double_click pulse one cycle after the second release; no short_press.
REQ-034 Hold 20 ms -> long_press at 10 ms; with KEY_EVENT_REPEAT_EN, repeat_pulse at 13, 16 and 19 ms; without it, no repeat_pulse.
REQ-035 Release exactly at the LONG_MS tick -> long_press only, then IDLE; second press exactly at the DCLICK_MS tick -> short_press and state PRESS1.
REQ-036 Reset asserted at 5 ms into a press, deasserted with the key still held, then release -> no pulses, busy = 0.
